fp_compare_pipe: RTL and testbench

Pipelined, multi-lane IEEE-754 compare and min/max unit for the FPU. It takes NUM_LANES operand pairs per transaction and performs EQ/LT/LE or MIN/MAX in SP or DP. Ingress and egress use valid/ready handshakes. It replaces single-shot combinational compare in the FPU issue path and carries an opaque tag for writeback.

---
 rtl/fp_compare_pipe.sv | 167 ++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined multi-lane IEEE-754 EQ/LT/LE/MIN/MAX unit; define FP_CMP_STICKY_NV_EN for a sticky NV flag
module fp_compare_pipe #(
   parameter int NUM_LANES = 2,
   parameter int LATENCY = 2,
   parameter int TAG_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  logic [2:0] in_op,
   input  logic in_dp,
   input  logic [64*NUM_LANES-1:0] in_a,
   input  logic [64*NUM_LANES-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic out_valid,
   input  logic out_ready,
   output logic [64*NUM_LANES-1:0] out_result,
   output logic [NUM_LANES-1:0] out_invalid,
   output logic [TAG_W-1:0] out_tag
`ifdef FP_CMP_STICKY_NV_EN
   ,output logic out_nv_sticky,
   input  logic clr_nv
`endif
);
   localparam int W = 64*NUM_LANES;
   localparam int RD = (LATENCY > 1) ? LATENCY - 1 : 1;

   function automatic logic [1:0] cls(input logic dp, input logic [63:0] x);
      logic nan;
      nan = dp ? (&x[62:52] && |x[51:0]) : (&x[30:23] && |x[22:0]);
      return {nan, nan && !(dp ? x[51] : x[22])};
   endfunction

   // order key: mapping sign-magnitude onto unsigned order puts -0 just below +0
   function automatic logic [64:0] lane_fn(input logic [2:0] op, input logic dp, input logic [63:0] a,
                                           input logic [63:0] b, input logic [1:0] ca, input logic [1:0] cb);
      logic [63:0] xa, xb, ka, kb, qn, mn, mx;
      logic za, zb, nan, snan, lt, eq;
      za = dp ? ~|a[62:0] : ~|a[30:0];
      zb = dp ? ~|b[62:0] : ~|b[30:0];
      xa = dp ? a : {a[31], 32'h0, a[30:0]};
      xb = dp ? b : {b[31], 32'h0, b[30:0]};
      ka = xa[63] ? ~xa : {1'b1, xa[62:0]};
      kb = xb[63] ? ~xb : {1'b1, xb[62:0]};
      nan = ca[1] | cb[1];
      snan = ca[0] | cb[0];
      eq = !nan && (a == b || (za && zb));
      lt = !nan && ka < kb && !(za && zb);
      qn = dp ? 64'h7FF8000000000000 : 64'h000000007FC00000;
      mn = (ca[1] && cb[1]) ? qn : ca[1] ? b : cb[1] ? a : (kb < ka) ? b : a;
      mx = (ca[1] && cb[1]) ? qn : ca[1] ? b : cb[1] ? a : (ka < kb) ? b : a;
      return op == 3'd0 ? {snan, 63'h0, eq} :
             op == 3'd1 ? {nan, 63'h0, lt} :
             op == 3'd2 ? {nan, 63'h0, lt | eq} :
             op == 3'd3 ? {snan, mn} :
             op == 3'd4 ? {snan, mx} : 65'h0;
   endfunction

   logic adv;
   logic [W-1:0] m_a, m_b, s_a, s_b, r_res;
   logic [2*NUM_LANES-1:0] m_ca, m_cb, s_ca, s_cb;
   logic [2:0] s_op;
   logic s_dp;
   logic [NUM_LANES-1:0] r_nv;
   logic [LATENCY-1:0] vld;
   logic [TAG_W-1:0] tag_q [LATENCY];
   logic [W-1:0] res_q [RD];
   logic [NUM_LANES-1:0] nv_q [RD];

   assign adv = !out_valid || out_ready;
   assign in_ready = adv;

   // SP lanes keep only their low word; NaN classes are derived from the masked operands
   always_comb begin
      m_a = '0;
      m_b = '0;
      m_ca = '0;
      m_cb = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         m_a[64*i+:64] = in_dp ? in_a[64*i+:64] : {32'h0, in_a[64*i+:32]};
         m_b[64*i+:64] = in_dp ? in_b[64*i+:64] : {32'h0, in_b[64*i+:32]};
         m_ca[2*i+:2] = cls(in_dp, m_a[64*i+:64]);
         m_cb[2*i+:2] = cls(in_dp, m_b[64*i+:64]);
      end
   end

   generate
      if (LATENCY > 1) begin : g_dec
         logic [2:0] d_op;
         logic d_dp;
         logic [W-1:0] d_a, d_b;
         logic [2*NUM_LANES-1:0] d_ca, d_cb;
         // stage 1 holds the decoded transaction
         always_ff @(posedge clk) begin
            if (adv) begin
               d_op <= in_op;
               d_dp <= in_dp;
               d_a <= m_a;
               d_b <= m_b;
               d_ca <= m_ca;
               d_cb <= m_cb;
            end
         end
         assign s_op = d_op;
         assign s_dp = d_dp;
         assign s_a = d_a;
         assign s_b = d_b;
         assign s_ca = d_ca;
         assign s_cb = d_cb;
      end else begin : g_nodec
         assign s_op = in_op;
         assign s_dp = in_dp;
         assign s_a = m_a;
         assign s_b = m_b;
         assign s_ca = m_ca;
         assign s_cb = m_cb;
      end
   endgenerate

   // evaluate every lane from the decoded operands
   always_comb begin
      r_res = '0;
      r_nv = '0;
      for (int i = 0; i < NUM_LANES; i++)
         {r_nv[i], r_res[64*i+:64]} = lane_fn(s_op, s_dp, s_a[64*i+:64], s_b[64*i+:64], s_ca[2*i+:2], s_cb[2*i+:2]);
   end

   // all stages move together on advance; results enter one stage after decode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
         for (int k = 0; k < RD; k++) begin
            res_q[k] <= '0;
            nv_q[k] <= '0;
         end
      end else if (adv) begin
         vld[0] <= in_valid;
         tag_q[0] <= in_tag;
         for (int k = 1; k < LATENCY; k++) begin
            vld[k] <= vld[k-1];
            tag_q[k] <= tag_q[k-1];
         end
         res_q[0] <= r_res;
         nv_q[0] <= r_nv;
         for (int k = 1; k < RD; k++) begin
            res_q[k] <= res_q[k-1];
            nv_q[k] <= nv_q[k-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_tag = tag_q[LATENCY-1];
   assign out_result = res_q[RD-1];
   assign out_invalid = nv_q[RD-1];

`ifdef FP_CMP_STICKY_NV_EN
   // remember any NV that completes a handshake until cleared; a set wins over a clear
   always_ff @(posedge clk) begin
      if (!rst_n) out_nv_sticky <= 1'b0;
      else if (out_valid && out_ready && |out_invalid) out_nv_sticky <= 1'b1;
      else if (clr_nv) out_nv_sticky <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed and randomized check of fp_compare_pipe against a real-arithmetic model
module tb_fp_compare_pipe;
   localparam int NL = 2;
   localparam int LAT = 2;
   localparam int TW = 5;
   localparam int W = 64*NL;

   logic clk = 0, rst_n = 0, in_valid = 0, in_dp = 0, out_ready = 1;
   logic [2:0] in_op = 0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic [TW-1:0] in_tag = '0;
   logic in_ready, out_valid;
   logic [W-1:0] out_result;
   logic [NL-1:0] out_invalid;
   logic [TW-1:0] out_tag;
`ifdef FP_CMP_STICKY_NV_EN
   logic out_nv_sticky;
   logic clr_nv = 0;
`endif

   int total = 0, bad = 0, cyc = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [NL-1:0] nv;
      logic [TW-1:0] tag;
   } exp_t;
   exp_t q[$];
   logic [TW-1:0] done_tags[$];

   fp_compare_pipe #(.NUM_LANES(NL), .LATENCY(LAT), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dp(in_dp),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_invalid(out_invalid), .out_tag(out_tag)
`ifdef FP_CMP_STICKY_NV_EN
      , .out_nv_sticky(out_nv_sticky), .clr_nv(clr_nv)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_nan(input logic dp, input logic [63:0] x);
      return dp ? (x[62:52] == 11'h7FF && x[51:0] != 0) : (x[30:23] == 8'hFF && x[22:0] != 0);
   endfunction

   function automatic real to_real(input logic dp, input logic [63:0] a);
      real m;
      int e;
      if (dp) return $bitstoreal(a);
      e = int'(a[30:23]);
      if (e == 255) m = $bitstoreal(64'h7FF0000000000000);
      else if (e == 0) m = real'(a[22:0]) * (2.0 ** (-149.0));
      else m = (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
      return a[31] ? -m : m;
   endfunction

   function automatic logic [64:0] m_lane(input logic [2:0] op, input logic dp, input logic [63:0] a0, input logic [63:0] b0);
      logic [63:0] a, b, qn;
      logic na, nb, sna, snb, sa, sb, a_less, b_less;
      real ra, rb;
      a = dp ? a0 : {32'h0, a0[31:0]};
      b = dp ? b0 : {32'h0, b0[31:0]};
      na = is_nan(dp, a);
      nb = is_nan(dp, b);
      sna = na && !(dp ? a[51] : a[22]);
      snb = nb && !(dp ? b[51] : b[22]);
      sa = dp ? a[63] : a[31];
      sb = dp ? b[63] : b[31];
      ra = to_real(dp, a);
      rb = to_real(dp, b);
      qn = dp ? 64'h7FF8000000000000 : 64'h000000007FC00000;
      a_less = ra < rb || (ra == rb && sa && !sb);
      b_less = rb < ra || (ra == rb && sb && !sa);
      case (op)
         3'd0: return {sna | snb, 63'h0, !na && !nb && ra == rb};
         3'd1: return {na | nb, 63'h0, !na && !nb && ra < rb};
         3'd2: return {na | nb, 63'h0, !na && !nb && ra <= rb};
         3'd3: return {sna | snb, (na && nb) ? qn : na ? b : nb ? a : b_less ? b : a};
         3'd4: return {sna | snb, (na && nb) ? qn : na ? b : nb ? a : a_less ? b : a};
         default: return 65'h0;
      endcase
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      logic [64:0] r;
      e.res = '0;
      e.nv = '0;
      e.tag = in_tag;
      for (int i = 0; i < NL; i++) begin
         r = m_lane(in_op, in_dp, in_a[64*i+:64], in_b[64*i+:64]);
         e.res[64*i+:64] = r[63:0];
         e.nv[i] = r[64];
      end
      return e;
   endfunction

   function automatic logic [63:0] gen(input logic dp, input logic [63:0] o);
      int k = $urandom_range(0, 9);
      logic s = 1'($urandom_range(0, 1));
      logic [63:0] r = {$urandom, $urandom};
      logic [63:0] v;
      if (dp)
         case (k)
            0: v = {s, 63'h0};
            1: v = {s, 11'h0, r[51:0]};
            2: v = {s, 11'h7FF, 52'h0};
            3: v = {s, 11'h7FF, 1'b1, r[50:0]};
            4: v = {s, 11'h7FF, 1'b0, r[50:1], 1'b1};
            5: v = o;
            6: v = o ^ 64'h1;
            default: v = {s, 11'h3FE + {9'h0, r[53:52]}, r[51:0]};
         endcase
      else
         case (k)
            0: v = {r[63:32], s, 31'h0};
            1: v = {r[63:32], s, 8'h0, r[22:0]};
            2: v = {r[63:32], s, 8'hFF, 23'h0};
            3: v = {r[63:32], s, 8'hFF, 1'b1, r[21:0]};
            4: v = {r[63:32], s, 8'hFF, 1'b0, r[21:1], 1'b1};
            5: v = {r[63:32], o[31:0]};
            6: v = {r[63:32], o[31:0] ^ 32'h1};
            default: v = {r[63:32], s, 8'h7E + {6'h0, r[24:23]}, r[22:0]};
         endcase
      return v;
   endfunction

   // scoreboard: every valid output is compared to the oldest accepted request, every cycle
   always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
         chk("in_ready", W'(in_ready), W'(!out_valid || out_ready));
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", W'(out_valid), '0);
            else begin
               chk("result", out_result, q[0].res);
               chk("invalid", W'(out_invalid), W'(q[0].nv));
               chk("tag", W'(out_tag), W'(q[0].tag));
               if (out_ready) begin
                  done_tags.push_back(q[0].tag);
                  void'(q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) q.push_back(expect_now());
      end
   end

   task automatic send(input logic [2:0] op, input logic dp, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int acc);
      in_valid = 1;
      in_op = op;
      in_dp = dp;
      in_a = a;
      in_b = b;
      in_tag = tag;
      acc = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc;
            break;
         end
      end
      chk("send_accept", W'(acc >= 0), W'(1));
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic wait_empty();
      for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
      chk("drain", W'(q.size()), '0);
      @(posedge clk);
      #1;
   endtask

   int acc, lat;
   logic seen;

   initial begin
      chk("model_lt", W'(m_lane(3'd1, 1, 64'h3FF0000000000000, 64'h4000000000000000)), W'({1'b0, 64'h1}));
      chk("model_eq_zero", W'(m_lane(3'd0, 1, 64'h8000000000000000, 64'h0)), W'({1'b0, 64'h1}));
      chk("model_min_zero", W'(m_lane(3'd3, 1, 64'h8000000000000000, 64'h0)), W'({1'b0, 64'h8000000000000000}));
      chk("model_max_zero", W'(m_lane(3'd4, 1, 64'h8000000000000000, 64'h0)), W'({1'b0, 64'h0}));
      chk("model_eq_snan", W'(m_lane(3'd0, 1, 64'h7FF0000000000001, 64'h3FF0000000000000)), W'({1'b1, 64'h0}));
      chk("model_min_snan", W'(m_lane(3'd3, 1, 64'h7FF0000000000001, 64'h3FF0000000000000)), W'({1'b1, 64'h3FF0000000000000}));
      chk("model_lt_qnan", W'(m_lane(3'd1, 1, 64'h7FF8000000000000, 64'h3FF0000000000000)), W'({1'b1, 64'h0}));
      chk("model_sp_max_nan", W'(m_lane(3'd4, 0, 64'hDEADBEEF7FC00000, 64'h00000000FFC00001)), W'({1'b0, 64'h7FC00000}));
      chk("model_sp_lt_denorm", W'(m_lane(3'd1, 0, 64'hFFFF000000000001, 64'h0000000000800000)), W'({1'b0, 64'h1}));

      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_out_result", out_result, '0);
      chk("rst_out_invalid", W'(out_invalid), '0);
      chk("rst_out_tag", W'(out_tag), '0);
      chk("rst_in_ready", W'(in_ready), W'(1));
`ifdef FP_CMP_STICKY_NV_EN
      chk("rst_sticky", W'(out_nv_sticky), '0);
`endif

      send(3'd1, 1, {64'h3FF0000000000000, 64'h3FF0000000000000}, {64'h3FF0000000000000, 64'h4000000000000000}, 5'd7, acc);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = out_valid;
      end
      lat = cyc - acc;
      chk("latency", W'(lat), W'(LAT));
      chk("t1_lane0", W'(out_result[63:0]), W'(64'h1));
      chk("t1_nv0", W'(out_invalid[0]), '0);
      chk("t1_tag", W'(out_tag), W'(5'd7));
      wait_empty();

      send(3'd0, 1, {64'h0, 64'h8000000000000000}, {64'h8000000000000000, 64'h0}, 5'd2, acc);
      send(3'd3, 1, {64'h0, 64'h8000000000000000}, {64'h8000000000000000, 64'h0}, 5'd3, acc);
      send(3'd4, 1, {64'h0, 64'h8000000000000000}, {64'h8000000000000000, 64'h0}, 5'd4, acc);
      wait_empty();
`ifdef FP_CMP_STICKY_NV_EN
      chk("sticky_quiet", W'(out_nv_sticky), '0);
`endif
      send(3'd0, 1, {64'hBFF0000000000000, 64'h7FF0000000000001}, {64'hBFF0000000000000, 64'h3FF0000000000000}, 5'd5, acc);
      send(3'd3, 1, {64'h7FF8000000000000, 64'h7FF0000000000001}, {64'h7FF4000000000000, 64'h3FF0000000000000}, 5'd6, acc);
      send(3'd1, 1, {64'h0000000000000001, 64'h7FF8000000000000}, {64'h0000000000000002, 64'h3FF0000000000000}, 5'd8, acc);
      wait_empty();
`ifdef FP_CMP_STICKY_NV_EN
      chk("sticky_set", W'(out_nv_sticky), W'(1));
      clr_nv = 1;
      @(posedge clk);
      #1 clr_nv = 0;
      chk("sticky_clr", W'(out_nv_sticky), '0);
`endif
      send(3'd4, 0, {64'hDEADBEEF7FC00000, 64'h12345678BF800000}, {64'h00000000FFC00001, 64'h000000003F800000}, 5'd9, acc);
      send(3'd6, 1, {64'h1, 64'h2}, {64'h3, 64'h4}, 5'd10, acc);
      wait_empty();

      out_ready = 0;
      done_tags.delete();
      send(3'd2, 1, {64'h4000000000000000, 64'hC000000000000000}, {64'h4000000000000000, 64'h8000000000000000}, 5'd1, acc);
      send(3'd3, 0, {64'h0, 64'h3F800000}, {64'h0, 64'hBF800000}, 5'd2, acc);
      in_valid = 1;
      in_op = 3'd4;
      in_dp = 1;
      in_a = {64'hFFF0000000000000, 64'h7FF0000000000000};
      in_b = {64'h0010000000000000, 64'h0};
      in_tag = 5'd3;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", W'(in_ready), '0);
      end
      @(posedge clk);
      #1 out_ready = 1;
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      @(posedge clk);
      #1 in_valid = 0;
      wait_empty();
      chk("bp_count", W'(done_tags.size()), W'(3));
      if (done_tags.size() == 3) begin
         chk("bp_order0", W'(done_tags[0]), W'(5'd1));
         chk("bp_order1", W'(done_tags[1]), W'(5'd2));
         chk("bp_order2", W'(done_tags[2]), W'(5'd3));
      end

      send(3'd1, 1, {64'h1, 64'h2}, {64'h3, 64'h4}, 5'd11, acc);
      send(3'd0, 1, {64'h1, 64'h2}, {64'h1, 64'h2}, 5'd12, acc);
      rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
      chk("midrst_valid", W'(out_valid), '0);
      chk("midrst_result", out_result, '0);
      chk("midrst_tag", W'(out_tag), '0);
`ifdef FP_CMP_STICKY_NV_EN
      chk("midrst_sticky", W'(out_nv_sticky), '0);
`endif
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_stale", W'(out_valid), '0);
      end

      for (int c = 0; c < 2500; c++) begin
         @(posedge clk);
         #1;
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         in_op = 3'($urandom_range(0, 7));
         in_dp = 1'($urandom_range(0, 1));
         in_tag = TW'($urandom);
         for (int i = 0; i < NL; i++) begin
            in_b[64*i+:64] = gen(in_dp, 64'h3FF0000000000000);
            in_a[64*i+:64] = gen(in_dp, in_b[64*i+:64]);
         end
      end
      @(posedge clk);
      #1 in_valid = 0;
      out_ready = 1;
      wait_empty();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
